mult_final_cpa: RTL and testbench

//  Final carry-propagate stage of the one-cycle 32x32 multiplier: consumes the redundant
//  sum/carry pair produced by the last adder-tree compressor level and resolves it into a
//  64-bit product. Selects the low (MUL) or high (MULH*) word and returns it to the ALU/EX

---
 rtl/mult_pkg.sv | 27 ++
 rtl/mult_cpa_half.sv | 22 ++
 rtl/mult_final_cpa.sv | 178 +++++++++++++++++
 tb/tb_mult_final_cpa.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier final carry-propagate stage.
//   MULT_W / PROD_W : operand word and full product widths
//   MULT_TAG_W      : default width of the opaque tag
//   mult_tag_t      : tag type at the default width
//   mult_cpa_req_t  : one redundant sum/carry request with its word select and tag
//   mult_sel_word() : picks the low or high word of a product
package mult_pkg;

  localparam int unsigned MULT_W     = 32;
  localparam int unsigned PROD_W     = 64;
  localparam int unsigned MULT_TAG_W = 4;

  typedef logic [MULT_TAG_W-1:0] mult_tag_t;

  typedef struct packed {
    logic [PROD_W-1:0] sum;
    logic [PROD_W-1:0] carry;
    logic              high_sel;
    mult_tag_t         tag;
  } mult_cpa_req_t;

  function automatic logic [MULT_W-1:0] mult_sel_word(input logic [PROD_W-1:0] prod,
                                                      input logic              high_sel);
    return high_sel ? prod[PROD_W-1:MULT_W] : prod[MULT_W-1:0];
  endfunction

endpackage

// File: rtl/mult_cpa_half.sv
// 32-bit carry-propagate adder slice with carry-in and carry-out.
//   a_i, b_i : addends
//   c_i      : carry in (weight 2^0)
//   s_o      : sum word
//   c_o      : carry out (weight 2^MULT_W)
module mult_cpa_half
  import mult_pkg::*;
(
  input  logic [MULT_W-1:0] a_i,
  input  logic [MULT_W-1:0] b_i,
  input  logic              c_i,
  output logic [MULT_W-1:0] s_o,
  output logic              c_o
);

  logic [MULT_W:0] sum_w;

  assign sum_w = {1'b0, a_i} + {1'b0, b_i} + {{MULT_W{1'b0}}, c_i};
  assign s_o   = sum_w[MULT_W-1:0];
  assign c_o   = sum_w[MULT_W];

endmodule

// File: rtl/mult_final_cpa.sv
// Final carry-propagate stage of the one-cycle 32x32 multiplier. Resolves the redundant
// sum/carry pair of the last compressor level into a 64-bit product and returns the low or
// high word through a valid/ready pipeline with tag passthrough and flush.
//
// Build option: define MULT_CPA_SPLIT_EN for a two-stage adder (low half, then high half plus
// the registered c32); latency 2, two ops in flight. Default is a single registered 64-bit add
// with latency 1.
//
// Ports:
//   clk, rst                : clock, asynchronous active-high reset
//   flush                   : synchronous kill of every in-flight op (beats a same-cycle accept)
//   in_valid/in_ready       : request handshake
//   in_sum, in_carry        : redundant pair; carry bit i has weight 2^(i+1), bit 63 is dropped
//   in_high_sel, in_tag     : word select and opaque tag
//   out_valid/out_ready     : result handshake
//   out_result, out_prod    : selected word and full product
//   out_tag                 : tag travelling with the result
module mult_final_cpa
  import mult_pkg::*;
#(
  parameter int unsigned TAG_W = MULT_TAG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_sum,
  input  logic [PROD_W-1:0] in_carry,
  input  logic              in_high_sel,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MULT_W-1:0] out_result,
  output logic [PROD_W-1:0] out_prod,
  output logic [TAG_W-1:0]  out_tag
);

  logic              in_fire;
  logic [MULT_W-1:0] lo_sum;
  logic              lo_cout;
  logic [MULT_W-1:0] hi_sum;
  logic              hi_cout;

  logic [PROD_W-1:0] prod_q;
  logic              high_q;
  logic [TAG_W-1:0]  tag_q;

  // Carry vector is pre-shifted by one: low slice sees {carry[30:0],0}, high slice carry[62:31].
  mult_cpa_half u_lo (
    .a_i (in_sum[MULT_W-1:0]),
    .b_i ({in_carry[MULT_W-2:0], 1'b0}),
    .c_i (1'b0),
    .s_o (lo_sum),
    .c_o (lo_cout)
  );

`ifdef MULT_CPA_SPLIT_EN

  logic              v0_q;
  logic              v1_q;
  logic [MULT_W-1:0] lo_q;
  logic              c32_q;
  logic [MULT_W-1:0] hs_q;
  logic [MULT_W-1:0] hc_q;
  logic              high0_q;
  logic [TAG_W-1:0]  tag0_q;
  logic              s1_ready;
  logic              s0_adv;

  mult_cpa_half u_hi (
    .a_i (hs_q),
    .b_i (hc_q),
    .c_i (c32_q),
    .s_o (hi_sum),
    .c_o (hi_cout)
  );

  assign s1_ready = !v1_q || out_ready;
  assign s0_adv   = v0_q && s1_ready;
  assign in_ready = !v0_q || s1_ready;
  assign in_fire  = in_valid && in_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
    end else if (flush) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
    end else begin
      if (in_ready) v0_q <= in_valid;
      if (s1_ready) v1_q <= v0_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_q    <= '0;
      c32_q   <= 1'b0;
      hs_q    <= '0;
      hc_q    <= '0;
      high0_q <= 1'b0;
      tag0_q  <= '0;
    end else if (in_fire) begin
      lo_q    <= lo_sum;
      c32_q   <= lo_cout;
      hs_q    <= in_sum[PROD_W-1:MULT_W];
      hc_q    <= in_carry[PROD_W-2:MULT_W-1];
      high0_q <= in_high_sel;
      tag0_q  <= in_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q <= '0;
      high_q <= 1'b0;
      tag_q  <= '0;
    end else if (s0_adv && !flush) begin
      prod_q <= {hi_sum, lo_q};
      high_q <= high0_q;
      tag_q  <= tag0_q;
    end
  end

  assign out_valid = v1_q;

`else

  logic v_q;

  mult_cpa_half u_hi (
    .a_i (in_sum[PROD_W-1:MULT_W]),
    .b_i (in_carry[PROD_W-2:MULT_W-1]),
    .c_i (lo_cout),
    .s_o (hi_sum),
    .c_o (hi_cout)
  );

  assign in_ready = !v_q || out_ready;
  assign in_fire  = in_valid && in_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= 1'b0;
    end else if (flush) begin
      v_q <= 1'b0;
    end else if (in_ready) begin
      v_q <= in_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q <= '0;
      high_q <= 1'b0;
      tag_q  <= '0;
    end else if (in_fire) begin
      prod_q <= {hi_sum, lo_sum};
      high_q <= in_high_sel;
      tag_q  <= in_tag;
    end
  end

  assign out_valid = v_q;

`endif

  assign out_prod   = prod_q;
  assign out_tag    = tag_q;
  assign out_result = mult_sel_word(prod_q, high_q);

  // The product is taken mod 2^64: the top carry bit and the final carry-out are discarded.
  logic unused_bits;
  assign unused_bits = ^{in_carry[PROD_W-1], hi_cout};

endmodule

// File: tb/tb_mult_final_cpa.sv
module tb_mult_final_cpa;
  import mult_pkg::*;

  localparam int unsigned TAG_W = MULT_TAG_W;
`ifdef MULT_CPA_SPLIT_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [63:0]       in_sum;
  logic [63:0]       in_carry;
  logic              in_high_sel;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_result;
  logic [63:0]       out_prod;
  logic [TAG_W-1:0]  out_tag;

  typedef struct {
    logic [63:0]      prod;
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    int               cyc;
    bit               chk_lat;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   n_acc = 0;
  int   n_acc0;
  logic [63:0] p_a;
  logic [TAG_W-1:0] t_a;

  always #5 clk = ~clk;

  mult_final_cpa #(.TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sum      (in_sum),
    .in_carry    (in_carry),
    .in_high_sel (in_high_sel),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_prod    (out_prod),
    .out_tag     (out_tag)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %h want %h", name, obs, expv);
    end
  endtask

  function automatic mult_cpa_req_t mk(input logic [63:0] s, input logic [63:0] c,
                                       input logic hs, input logic [TAG_W-1:0] t);
    mult_cpa_req_t r;
    r.sum      = s;
    r.carry    = c;
    r.high_sel = hs;
    r.tag      = t;
    return r;
  endfunction

  function automatic logic [63:0] model(input mult_cpa_req_t r);
    return r.sum + {r.carry[62:0], 1'b0};
  endfunction

  // Drive one request, wait for acceptance (bounded), push its expectation.
  task automatic send(input mult_cpa_req_t r, input bit chk_lat);
    exp_t e;
    logic [63:0] p;
    bit acc;
    int w;
    p         = model(r);
    e.prod    = p;
    e.res     = r.high_sel ? p[63:32] : p[31:0];
    e.tag     = r.tag;
    e.chk_lat = chk_lat;
    in_sum      = r.sum;
    in_carry    = r.carry;
    in_high_sel = r.high_sel;
    in_tag      = r.tag;
    in_valid    = 1'b1;
    acc = 1'b0;
    w   = 0;
    while (!acc && w < 50) begin
      @(negedge clk);
      if (in_ready && !flush && !rst) begin
        e.cyc = cyc;
        sb.push_back(e);
        n_acc++;
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
      w++;
    end
    in_valid = 1'b0;
    if (!acc) chk("send_accept", {63'd0, acc}, 64'd1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_sum = '0; in_carry = '0; in_high_sel = 1'b0; in_tag = '0;

    fork
      forever begin
        @(posedge clk);
        cyc++;
      end
      forever begin
        @(negedge clk);
        if (rst || flush) begin
          sb.delete();
        end else if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("spurious_out", {63'd0, out_valid}, 64'd0);
          end else begin
            me = sb.pop_front();
            chk("prod", out_prod, me.prod);
            chk("result", {32'd0, out_result}, {32'd0, me.res});
            chk("tag", 64'(out_tag), 64'(me.tag));
            if (me.chk_lat) chk("latency", 64'(cyc - me.cyc), 64'(LAT));
          end
        end
      end
      begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset values
    #3;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_result", {32'd0, out_result}, 64'd0);
    chk("rst_out_prod", out_prod, 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // c32 propagation into the high word
    send(mk(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b1, 4'd1), 1'b1);
    drain();

    // carry[63] dropped, all-ones wraparound
    send(mk(64'h1, 64'h8000_0000_0000_0000, 1'b0, 4'd2), 1'b1);
    send(mk('1, '1, 1'b0, 4'd3), 1'b1);
    send(mk('1, '1, 1'b1, 4'd4), 1'b1);
    drain();

    // Back-to-back with tags 0..7
    for (int i = 0; i < 8; i++) begin
      send(mk(64'((i + 1) * (i + 6)), 64'd0, 1'b0, 4'(i)), 1'b1);
    end
    drain();

    // Random redundant pairs
    for (int i = 0; i < 8; i++) begin
      send(mk({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 4'(i + 8)),
           1'b1);
    end
    drain();

    // Backpressure: hold out_ready low for 5 cycles while requests keep coming
    n_acc0 = n_acc;
    p_a = model(mk(64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1, 4'd5));
    t_a = 4'd5;
    out_ready = 1'b0;
    fork
      begin
        send(mk(64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1, 4'd5), 1'b0);
        send(mk(64'hFFFF_0000_FFFF_0000, 64'h7FFF_FFFF_0000_0001, 1'b0, 4'd6), 1'b0);
        send(mk(64'h0000_0001_8000_0000, 64'h4000_0000_4000_0000, 1'b1, 4'd7), 1'b0);
      end
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          if (k >= LAT) begin
            chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_out_prod", out_prod, p_a);
            chk("bp_out_tag", 64'(out_tag), 64'(t_a));
          end
        end
        chk("bp_accepts", 64'(n_acc - n_acc0), 64'(LAT));
        chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Flush with the pipeline full and a request at the input
    out_ready = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      send(mk(64'(i + 100), 64'(i), 1'b0, 4'(i + 9)), 1'b0);
    end
    in_sum = 64'hDEAD; in_carry = 64'h1; in_high_sel = 1'b0; in_tag = 4'd15;
    in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    end
    @(posedge clk); #1;
    send(mk(64'h55, 64'h0000_0001_0000_0000, 1'b1, 4'd12), 1'b1);
    drain();

    // Asynchronous reset in the middle of a stream
    send(mk(64'hAAAA_AAAA_AAAA_AAAA, 64'h1111, 1'b1, 4'd13), 1'b0);
    send(mk(64'h5555_5555_5555_5555, 64'h2222, 1'b1, 4'd14), 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_out_result", {32'd0, out_result}, 64'd0);
    chk("arst_out_prod", out_prod, 64'd0);
    @(posedge clk);
    @(posedge clk); #4;
    rst = 1'b0;
    @(negedge clk);
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("arst_idle_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    send(mk(64'h0000_0000_8000_0000, 64'h0000_0000_4000_0000, 1'b1, 4'd0), 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
